// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_pkg
//  Description : Shared RV32I definitions. This package holds the op_class
//                codes, the major opcodes and the funct3 values. The encoder
//                and the decoder both import it. It also provides helpers
//                that map an op_class to its instruction format and opcode.
//  Revision    : 1.0  initial release
// ============================================================================
package instr_encoder_pkg;

    // op_class codes; 11..15 are reserved
    localparam logic [3:0] c_cls_lui    = 4'd0;
    localparam logic [3:0] c_cls_auipc  = 4'd1;
    localparam logic [3:0] c_cls_jal    = 4'd2;
    localparam logic [3:0] c_cls_jalr   = 4'd3;
    localparam logic [3:0] c_cls_branch = 4'd4;
    localparam logic [3:0] c_cls_load   = 4'd5;
    localparam logic [3:0] c_cls_store  = 4'd6;
    localparam logic [3:0] c_cls_imm    = 4'd7;
    localparam logic [3:0] c_cls_alu    = 4'd8;
    localparam logic [3:0] c_cls_fence  = 4'd9;
    localparam logic [3:0] c_cls_system = 4'd10;
    localparam logic [3:0] c_cls_max    = 4'd10;

    // Major opcodes
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_imm    = 7'b0010011;
    localparam logic [6:0] c_opc_alu    = 7'b0110011;
    localparam logic [6:0] c_opc_fence  = 7'b0001111;
    localparam logic [6:0] c_opc_system = 7'b1110011;

    // funct3 values that need special handling
    localparam logic [2:0] c_f3_sll     = 3'b001;   // SLLI
    localparam logic [2:0] c_f3_sr      = 3'b101;   // SRLI / SRAI
    localparam logic [2:0] c_f3_br_r0   = 3'b010;   // unused branch conditions
    localparam logic [2:0] c_f3_br_r1   = 3'b011;
    localparam logic [2:0] c_f3_ld_r0   = 3'b011;   // unused load widths
    localparam logic [2:0] c_f3_ld_r1   = 3'b110;
    localparam logic [2:0] c_f3_ld_r2   = 3'b111;
    localparam logic [2:0] c_f3_sw      = 3'b010;   // widest store

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    function automatic fmt_e fmt_of(input logic [3:0] cls);
        case (cls)
            c_cls_alu:                                   return FMT_R;
            c_cls_jalr, c_cls_load, c_cls_imm,
            c_cls_fence, c_cls_system:                   return FMT_I;
            c_cls_store:                                 return FMT_S;
            c_cls_branch:                                return FMT_B;
            c_cls_lui, c_cls_auipc:                      return FMT_U;
            c_cls_jal:                                   return FMT_J;
            default:                                     return FMT_NONE;
        endcase
    endfunction

    function automatic logic [6:0] opcode_of(input logic [3:0] cls);
        case (cls)
            c_cls_lui:    return c_opc_lui;
            c_cls_auipc:  return c_opc_auipc;
            c_cls_jal:    return c_opc_jal;
            c_cls_jalr:   return c_opc_jalr;
            c_cls_branch: return c_opc_branch;
            c_cls_load:   return c_opc_load;
            c_cls_store:  return c_opc_store;
            c_cls_imm:    return c_opc_imm;
            c_cls_alu:    return c_opc_alu;
            c_cls_fence:  return c_opc_fence;
            c_cls_system: return c_opc_system;
            default:      return 7'b0000000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_imm_pack.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_imm_pack
//  Description : Combinational immediate packer. It places the immediate bits
//                into their instruction-word positions for the format chosen
//                by op_class. It also flags values that cannot be encoded.
//                Shift-immediate forms are handled here as well, including
//                the funct7 bits of those forms.
//  Ports       : i_op_class  op_class code
//                i_funct3    funct3, selects the shift-immediate forms
//                i_alt       funct7[5] for SRAI
//                i_imm       unpacked signed immediate
//                o_imm_bits  immediate/funct7 bits in place, all other bits 0
//                o_imm_err   immediate not encodable for this format
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encoder_imm_pack (
    input  logic [3:0]  i_op_class,
    input  logic [2:0]  i_funct3,
    input  logic        i_alt,
    input  logic [31:0] i_imm,
    output logic [31:0] o_imm_bits,
    output logic        o_imm_err
);
    import instr_encoder_pkg::*;

    fmt_e w_fmt;
    logic w_fits12;
    logic w_fits13;
    logic w_fits21;
    logic w_shift;

    always_comb begin
        w_fmt    = fmt_of(i_op_class);
        // Fits an N-bit signed field when every bit above N-1 copies bit N-1
        w_fits12 = (i_imm[31:11] == {21{i_imm[11]}});
        w_fits13 = (i_imm[31:12] == {20{i_imm[12]}});
        w_fits21 = (i_imm[31:20] == {12{i_imm[20]}});
        w_shift  = (i_op_class == c_cls_imm) &&
                   ((i_funct3 == c_f3_sll) || (i_funct3 == c_f3_sr));

        o_imm_bits = '0;
        o_imm_err  = 1'b0;
        case (w_fmt)
            FMT_I: begin
                if (w_shift) begin
                    // shamt in [24:20]; funct7[5] only exists for SRAI
                    o_imm_bits = {1'b0, i_alt & (i_funct3 == c_f3_sr), 5'b0,
                                  i_imm[4:0], 20'b0};
                    o_imm_err  = (|i_imm[31:5]) | (i_alt & (i_funct3 == c_f3_sll));
                end else begin
                    o_imm_bits = {i_imm[11:0], 20'b0};
                    o_imm_err  = ~w_fits12;
                end
            end
            FMT_S: begin
                o_imm_bits = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
                o_imm_err  = ~w_fits12;
            end
            FMT_B: begin
                o_imm_bits = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
                o_imm_err  = ~w_fits13 | i_imm[0];
            end
            FMT_U: begin
                o_imm_bits = {i_imm[31:12], 12'b0};
                o_imm_err  = |i_imm[11:0];
            end
            FMT_J: begin
                o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
                o_imm_err  = ~w_fits21 | i_imm[0];
            end
            default: begin
                o_imm_bits = '0;
                o_imm_err  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : RV32I instruction encoder. It turns an unpacked field set
//                into a 32-bit word. Words that cannot be encoded come out
//                as zero with the illegal flag set. Output is buffered in an
//                output register plus one skid entry. Counters track
//                delivered legal words and delivered illegal words.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                in_valid/in_ready  input handshake (in_ready = skid empty)
//                op_class, rd, rs1, rs2, funct3, alt, imm  field set
//                out_valid/out_ready output handshake
//                instr, illegal     encoded word and its illegal flag
//                enc_count          legal words delivered (wraps)
//                err_count          illegal words delivered (saturates)
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_class,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        illegal,
    output logic [15:0] enc_count,
    output logic [7:0]  err_count
);
    import instr_encoder_pkg::*;

    // ------------------------------------------------------------------
    // Field encoding
    // ------------------------------------------------------------------
    logic [31:0] w_imm_bits;
    logic        w_imm_err;
    fmt_e        w_fmt;
    logic        w_is_fence;
    logic [4:0]  w_rd_f;
    logic [4:0]  w_rs1_f;
    logic [4:0]  w_rs2_f;
    logic [2:0]  w_f3_f;
    logic [6:0]  w_f7_f;
    logic        w_f3_err;
    logic        w_illegal;
    logic [31:0] w_instr;

    instr_encoder_imm_pack u_imm_pack (
        .i_op_class (op_class),
        .i_funct3   (funct3),
        .i_alt      (alt),
        .i_imm      (imm),
        .o_imm_bits (w_imm_bits),
        .o_imm_err  (w_imm_err)
    );

    always_comb begin
        w_fmt      = fmt_of(op_class);
        w_is_fence = (op_class == c_cls_fence);
        w_rd_f     = '0;
        w_rs1_f    = '0;
        w_rs2_f    = '0;
        w_f3_f     = '0;
        w_f7_f     = '0;
        case (w_fmt)
            FMT_R: begin
                w_rd_f  = rd;
                w_rs1_f = rs1;
                w_rs2_f = rs2;
                w_f3_f  = funct3;
                w_f7_f  = {1'b0, alt, 5'b0};
            end
            FMT_I: begin
                // FENCE keeps rd and rs1 at zero
                w_rd_f  = w_is_fence ? 5'd0 : rd;
                w_rs1_f = w_is_fence ? 5'd0 : rs1;
                w_f3_f  = funct3;
            end
            FMT_S, FMT_B: begin
                w_rs1_f = rs1;
                w_rs2_f = rs2;
                w_f3_f  = funct3;
            end
            FMT_U, FMT_J: begin
                w_rd_f  = rd;
            end
            default: begin
                w_rd_f  = '0;
            end
        endcase

        w_f3_err = 1'b0;
        case (op_class)
            c_cls_branch: w_f3_err = (funct3 == c_f3_br_r0) || (funct3 == c_f3_br_r1);
            c_cls_load:   w_f3_err = (funct3 == c_f3_ld_r0) || (funct3 == c_f3_ld_r1) ||
                                     (funct3 == c_f3_ld_r2);
            c_cls_store:  w_f3_err = (funct3 > c_f3_sw);
            default:      w_f3_err = 1'b0;
        endcase

        w_illegal = (op_class > c_cls_max) | w_f3_err | w_imm_err;
        w_instr   = w_illegal ? 32'd0 :
                    (w_imm_bits | {w_f7_f, w_rs2_f, w_rs1_f, w_f3_f, w_rd_f, opcode_of(op_class)});
    end

    // ------------------------------------------------------------------
    // Output register + skid entry, counters
    // ------------------------------------------------------------------
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic        r_out_illegal;
    logic        r_skid_valid;
    logic [31:0] r_skid_instr;
    logic        r_skid_illegal;
    logic [15:0] r_enc_count;
    logic [7:0]  r_err_count;
    logic        w_in_fire;
    logic        w_out_fire;

    assign in_ready   = ~r_skid_valid;
    assign w_in_fire  = in_valid & ~r_skid_valid;
    assign w_out_fire = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_instr    <= '0;
            r_out_illegal  <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_instr   <= '0;
            r_skid_illegal <= 1'b0;
            r_enc_count    <= '0;
            r_err_count    <= '0;
        end else begin
            if (w_out_fire) begin
                // Skid is older than anything arriving now, so it goes first.
                // No input can arrive while the skid is full.
                if (r_skid_valid) begin
                    r_out_instr   <= r_skid_instr;
                    r_out_illegal <= r_skid_illegal;
                    r_skid_valid  <= 1'b0;
                end else if (w_in_fire) begin
                    r_out_instr   <= w_instr;
                    r_out_illegal <= w_illegal;
                end else begin
                    r_out_valid   <= 1'b0;
                end
                if (r_out_illegal) begin
                    if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end else begin
                    r_enc_count <= r_enc_count + 16'd1;
                end
            end else if (w_in_fire) begin
                if (!r_out_valid) begin
                    r_out_instr   <= w_instr;
                    r_out_illegal <= w_illegal;
                    r_out_valid   <= 1'b1;
                end else begin
                    r_skid_instr   <= w_instr;
                    r_skid_illegal <= w_illegal;
                    r_skid_valid   <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign instr     = r_out_instr;
    assign illegal   = r_out_illegal;
    assign enc_count = r_enc_count;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder. Expected words come
//                from a decoder round-trip reference model that works on the
//                field level.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

    localparam logic [3:0] c_lui = 4'd0, c_auipc = 4'd1, c_jal = 4'd2, c_jalr = 4'd3;
    localparam logic [3:0] c_br  = 4'd4, c_ld = 4'd5, c_st = 4'd6, c_imm = 4'd7;
    localparam logic [3:0] c_alu = 4'd8, c_fence = 4'd9, c_sys = 4'd10;

    typedef struct packed {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] imm;
    } fields_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_class;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        illegal;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_class  (op_class),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .alt       (alt),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .illegal   (illegal),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    // ---------------- reference model ----------------
    function automatic bit model_illegal(input fields_t f);
        int s;
        s = int'($signed(f.imm));
        case (f.cls)
            c_lui, c_auipc: return (f.imm % 4096) != 0;
            c_jal:          return (s < -1048576) || (s > 1048575) || (f.imm % 2 != 0);
            c_br:           return (s < -4096) || (s > 4095) || (f.imm % 2 != 0) ||
                                   (f.f3 == 3'd2) || (f.f3 == 3'd3);
            c_ld:           return (s < -2048) || (s > 2047) || (f.f3 == 3'd3) || (f.f3 >= 3'd6);
            c_st:           return (s < -2048) || (s > 2047) || (f.f3 > 3'd2);
            c_jalr, c_fence, c_sys: return (s < -2048) || (s > 2047);
            c_imm: begin
                if (f.f3 == 3'd1) return (f.imm > 32'd31) || f.alt;
                if (f.f3 == 3'd5) return (f.imm > 32'd31);
                return (s < -2048) || (s > 2047);
            end
            c_alu:          return 1'b0;
            default:        return 1'b1;
        endcase
    endfunction

    // Fields that a decoder is expected to recover; unused ones are zero
    function automatic fields_t normalize(input fields_t f);
        fields_t n;
        n = '0;
        n.cls = f.cls;
        case (f.cls)
            c_lui, c_auipc, c_jal: begin n.rd = f.rd; n.imm = f.imm; end
            c_jalr, c_ld, c_sys: begin n.rd = f.rd; n.rs1 = f.rs1; n.f3 = f.f3; n.imm = f.imm; end
            c_fence: begin n.f3 = f.f3; n.imm = f.imm; end
            c_st, c_br: begin n.rs1 = f.rs1; n.rs2 = f.rs2; n.f3 = f.f3; n.imm = f.imm; end
            c_imm: begin
                n.rd = f.rd; n.rs1 = f.rs1; n.f3 = f.f3; n.imm = f.imm;
                n.alt = (f.f3 == 3'd5) ? f.alt : 1'b0;
            end
            c_alu: begin n.rd = f.rd; n.rs1 = f.rs1; n.rs2 = f.rs2; n.f3 = f.f3; n.alt = f.alt; end
            default: n = '0;
        endcase
        return n;
    endfunction

    function automatic fields_t decode(input logic [31:0] w);
        fields_t d;
        bit ityp;
        d = '0;
        ityp = 1'b0;
        case (w[6:0])
            7'b0110111: begin d.cls = c_lui;   d.rd = w[11:7]; d.imm = {w[31:12], 12'b0}; end
            7'b0010111: begin d.cls = c_auipc; d.rd = w[11:7]; d.imm = {w[31:12], 12'b0}; end
            7'b1101111: begin
                d.cls = c_jal; d.rd = w[11:7];
                d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'b1100111: begin d.cls = c_jalr;  ityp = 1'b1; end
            7'b0000011: begin d.cls = c_ld;    ityp = 1'b1; end
            7'b1110011: begin d.cls = c_sys;   ityp = 1'b1; end
            7'b0001111: begin d.cls = c_fence; ityp = 1'b1; end
            7'b1100011: begin
                d.cls = c_br; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f3 = w[14:12];
                d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            7'b0100011: begin
                d.cls = c_st; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f3 = w[14:12];
                d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            7'b0010011: begin
                d.cls = c_imm; d.rd = w[11:7]; d.rs1 = w[19:15]; d.f3 = w[14:12];
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                    d.imm = {27'b0, w[24:20]}; d.alt = w[30];
                    if (w[31] || (w[29:25] != 5'd0)) d.cls = 4'hF;
                end else begin
                    d.imm = {{20{w[31]}}, w[31:20]};
                end
            end
            7'b0110011: begin
                d.cls = c_alu; d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
                d.f3 = w[14:12]; d.alt = w[30];
                if (w[31] || (w[29:25] != 5'd0)) d.cls = 4'hF;
            end
            default: d.cls = 4'hF;
        endcase
        if (ityp) begin
            d.rd = w[11:7]; d.rs1 = w[19:15]; d.f3 = w[14:12];
            d.imm = {{20{w[31]}}, w[31:20]};
        end
        return d;
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        int v;
        f.cls = 4'($urandom_range(0, 12));
        f.rd  = 5'($urandom);
        f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom);
        f.f3  = 3'($urandom);
        f.alt = 1'($urandom);
        case ($urandom_range(0, 4))
            0: f.imm = $urandom;
            1: begin v = int'($urandom_range(0, 8191)) - 4096; f.imm = v; end
            2: begin v = int'($urandom_range(0, 2097151)) - 1048576; f.imm = v; end
            3: f.imm = $urandom & 32'hFFFFF000;
            default: f.imm = $urandom_range(0, 40);
        endcase
        if ($urandom_range(0, 1) == 1) f.imm = f.imm & 32'hFFFFFFFE;
        return f;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input fields_t f);
        op_class = f.cls; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2;
        funct3 = f.f3; alt = f.alt; imm = f.imm;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive('0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_word(input fields_t f);
        drive(f);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic fields_t mk(input logic [3:0] c, input logic [4:0] d, input logic [4:0] s1,
                                   input logic [4:0] s2, input logic [2:0] f, input logic a,
                                   input logic [31:0] i);
        fields_t r;
        r.cls = c; r.rd = d; r.rs1 = s1; r.rs2 = s2; r.f3 = f; r.alt = a; r.imm = i;
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr !== 32'd0 || illegal !== 1'b0 ||
            enc_count !== 16'd0 || err_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_state: ov=%b ir=%b instr=%h ill=%b enc=%0d err=%0d, want 0 1 0 0 0 0",
                     out_valid, in_ready, instr, illegal, enc_count, err_count);
        end
    endtask

    task automatic test_directed();
        fields_t     vec [5];
        logic [31:0] w_exp [5];
        logic        i_exp [5];
        logic [15:0] e_exp [5];
        logic [7:0]  r_exp [5];
        vec[0] = mk(c_imm, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);  w_exp[0] = 32'h00500093;
        vec[1] = mk(c_st,  5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8);  w_exp[1] = 32'h0020A423;
        vec[2] = mk(c_alu, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);  w_exp[2] = 32'h402081B3;
        vec[3] = mk(c_jal, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4);  w_exp[3] = 32'h004000EF;
        vec[4] = mk(c_br,  5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3);  w_exp[4] = 32'h00000000;
        i_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        e_exp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd4};
        r_exp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push_word(vec[k]);
            total++;
            if (out_valid !== 1'b1 || instr !== w_exp[k] || illegal !== i_exp[k]) begin
                bad++;
                $display("FAIL directed_word[%0d]: ov=%b instr=%h ill=%b, want 1 %h %b",
                         k, out_valid, instr, illegal, w_exp[k], i_exp[k]);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            total++;
            if (enc_count !== e_exp[k] || err_count !== r_exp[k] || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL directed_count[%0d]: enc=%0d err=%0d ov=%b, want %0d %0d 0",
                         k, enc_count, err_count, out_valid, e_exp[k], r_exp[k]);
            end
        end
    endtask

    task automatic test_skid();
        logic [31:0] want [3];
        int got;
        bool_fire: begin end
        want = '{32'h00100093, 32'h00200093, 32'h00300093};
        do_reset();
        push_word(mk(c_imm, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1));
        push_word(mk(c_imm, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2));
        drive(mk(c_imm, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3));
        in_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || instr !== want[0]) begin
            bad++;
            $display("FAIL skid_hold: ir=%b ov=%b instr=%h, want 0 1 %h", in_ready, out_valid, instr, want[0]);
        end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            logic fi;
            fi = in_valid & in_ready;
            if (out_valid) begin
                total++;
                if (got >= 3 || instr !== want[got]) begin
                    bad++;
                    $display("FAIL skid_order[%0d]: instr=%h, want %h", got, instr,
                             (got < 3) ? want[got] : 32'hxxxxxxxx);
                end
                got++;
            end
            @(posedge clk); #1;
            if (fi) in_valid = 1'b0;
        end
        total++;
        if (got != 3 || enc_count !== 16'd3) begin
            bad++;
            $display("FAIL skid_count: delivered=%0d enc=%0d, want 3 3", got, enc_count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_word(mk(c_imm, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1));
        push_word(mk(c_br,  5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3));
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_full: ir=%b ov=%b, want 0 1", in_ready, out_valid);
        end
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || enc_count !== 16'd0 || err_count !== 8'd0 ||
            instr !== 32'd0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_state: ov=%b ir=%b enc=%0d err=%0d instr=%h ill=%b, want 0 1 0 0 0 0",
                     out_valid, in_ready, enc_count, err_count, instr, illegal);
        end
        repeat (2) @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || enc_count !== 16'd0 || err_count !== 8'd0) begin
            bad++;
            $display("FAIL rstmid_nodeliver: ov=%b enc=%0d err=%0d, want 0 0 0", out_valid, enc_count, err_count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random(input int n);
        fields_t     q[$];
        fields_t     cur, exp_f, got_f;
        logic [15:0] m_enc;
        logic [7:0]  m_err;
        logic        fi, fo;
        do_reset();
        m_enc = '0; m_err = '0;
        cur = '0;
        for (int c = 0; c < n + 20; c++) begin
            if (c < n) begin
                if (!in_valid && $urandom_range(0, 3) != 0) begin
                    cur = rand_fields();
                    drive(cur);
                    in_valid = 1'b1;
                end
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            fi = in_valid & in_ready;
            fo = out_valid & out_ready;
            if (fo) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra: instr=%h delivered with empty model queue", instr);
                end else begin
                    exp_f = q.pop_front();
                    if (model_illegal(exp_f)) begin
                        if (illegal !== 1'b1 || instr !== 32'd0) begin
                            bad++;
                            $display("FAIL rand_illegal: cls=%0d f3=%0d imm=%h got instr=%h ill=%b, want 0 1",
                                     exp_f.cls, exp_f.f3, exp_f.imm, instr, illegal);
                        end
                        if (m_err != 8'hFF) m_err = m_err + 8'd1;
                    end else begin
                        got_f = decode(instr);
                        if (illegal !== 1'b0 || got_f !== normalize(exp_f)) begin
                            bad++;
                            $display("FAIL rand_word: cls=%0d f3=%0d imm=%h got instr=%h ill=%b decoded=%h, want %h",
                                     exp_f.cls, exp_f.f3, exp_f.imm, instr, illegal, got_f, normalize(exp_f));
                        end
                        m_enc = m_enc + 16'd1;
                    end
                end
            end
            if (fi) q.push_back(cur);
            @(posedge clk); #1;
            if (fi) in_valid = 1'b0;
            total++;
            if (enc_count !== m_enc || err_count !== m_err) begin
                bad++;
                $display("FAIL rand_counts: enc=%0d err=%0d, want %0d %0d", enc_count, err_count, m_enc, m_err);
            end
        end
        total++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rand_drain: left=%0d ov=%b, want 0 0", q.size(), out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        drive(mk(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (300) @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (err_count !== 8'hFF || enc_count !== 16'd0) begin
            bad++;
            $display("FAIL err_saturate: err=%0d enc=%0d, want 255 0", err_count, enc_count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        drive(mk(c_imm, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (65535) @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (enc_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL enc_before_wrap: enc=%h, want ffff", enc_count);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (enc_count !== 16'h0000 || err_count !== 8'd0) begin
            bad++;
            $display("FAIL enc_wrap: enc=%h err=%0d, want 0000 0", enc_count, err_count);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_class = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; alt = 1'b0; imm = '0;
        test_reset();
        test_directed();
        test_skid();
        test_reset_mid();
        test_random(1500);
        test_saturate();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  input field set valid.
REQ-004 in_ready  out  1  encoder can accept; registered, equals "skid entry empty".
REQ-005 op_class  in  4  0=LUI 1=AUIPC 2=JAL 3=JALR 4=BRANCH 5=LOAD 6=STORE 7=IMM 8=ALU 9=FENCE 10=SYSTEM; 11-15 reserved.
REQ-006 rd, rs1, rs2  in  5 each  register indices.
REQ-007 funct3  in  3  minor opcode / branch cond / load-store width.
REQ-008 alt  in  1  funct7[5] select (SUB/SRA/SRAI).
REQ-009 imm  in  32  signed byte-offset/immediate value, unpacked.
REQ-010 out_valid  out  1  instr word valid.
REQ-011 out_ready  in  1  downstream accepts.
REQ-012 instr  out  32  encoded RV32I word.
REQ-013 illegal  out  1  qualifies instr; field combination not encodable.
REQ-014 enc_count  out  16  legal words delivered, wraps 0xFFFF->0.
REQ-015 err_count  out  8  illegal words delivered, saturates at 0xFF.

Function
REQ-016 Transfer occurs on in_valid&in_ready (input) and out_valid&out_ready (output); no other event moves data.
REQ-017 Buffer = output register + one skid entry; latency 1 cycle (accept at edge N -> out_valid after N); throughput 1 word/cycle when out_ready held high.
REQ-018 Input accepted while output register empty or draining same cycle goes to output register; otherwise to skid entry; in_ready deasserts next cycle.
REQ-019 On output transfer with skid full, skid moves to output register and in_ready reasserts next cycle; strict FIFO order always.
REQ-020 Simultaneous input and output transfer with skid empty: output register reloads with new word, out_valid stays 1.
REQ-021 Opcode [6:0]: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, IMM 0010011, ALU 0110011, FENCE 0001111, SYSTEM 1110011.
REQ-022 Formats: R=ALU; I=JALR,LOAD,IMM,FENCE,SYSTEM; S=STORE; B=BRANCH; U=LUI,AUIPC; J=JAL.
REQ-023 Packing: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12]->31, imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->7; U imm[31:12]->[31:12]; J imm[20]->31, imm[10:1]->[30:21], imm[11]->20, imm[19:12]->[19:12].
REQ-024 ALU funct7 = {0,alt,00000}; IMM with funct3 001/101 uses [31:25]={0,alt,00000}, [24:20]=imm[4:0].
REQ-025 FENCE forces rd=rs1=0; LUI/AUIPC/JAL ignore rs1/rs2; fields not in format are zero.
REQ-026 illegal=1 when: op_class>10; I/S imm not sign-extended 12-bit; B imm not 13-bit signed or imm[0]=1; J imm not 21-bit signed or imm[0]=1; U imm[11:0]!=0; shift imm outside 0..31; alt=1 on SLLI; BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3>010.
REQ-027 illegal word: instr=0x00000000, illegal=1; still passes through buffer in order.
REQ-028 enc_count/err_count update only on output transfer, per illegal flag.

Reset
REQ-029 rst: out_valid=0, skid empty, in_ready=1 next cycle, instr=0, illegal=0, enc_count=0, err_count=0.
REQ-030 rst mid-operation discards buffered words without delivery; counters not incremented that cycle.

Structure
REQ-031 Opcode constants, op_class codes, funct3 constants in shared defines package, common with decoder.
REQ-032 One combinational sub-module imm_pack (op_class, imm -> packed bits + range-error flag); handshake/buffer/counters in top.

Verification
REQ-033 IMM rd=1 rs1=0 f3=000 imm=5 -> instr 0x00500093, illegal=0, enc_count=1.
REQ-034 STORE rs1=1 rs2=2 f3=010 imm=8 -> 0x0020A423; ALU rd=3 rs1=1 rs2=2 f3=000 alt=1 -> 0x402081B3.
REQ-035 JAL rd=1 imm=4 -> 0x004000EF; BRANCH imm=3 -> instr 0, illegal=1, err_count=1.
REQ-036 out_ready=0 three cycles, in_valid=1 with words A,B,C: A,B accepted, in_ready=0, C held; release -> A,B,C delivered in order, no loss/dup.
REQ-037 rst asserted with two words buffered -> out_valid=0, in_ready=1 next cycle, counters 0, neither word delivered.
REQ-038 Random streams with random out_ready vs decoder round-trip model; 65536 legal words -> enc_count wraps to 0.
